// File: rtl/conv_result_streamer.sv
// conv_result_streamer
//   Captures the convolution result array and its cycle count on the rising
//   edge of conv_done, then drains them as a valid/ready beat stream: all
//   ROWS*COLS elements in row-major order, followed by one trailer beat that
//   carries the cycle count. Because the data is held in a local snapshot,
//   the convolution engine may start its next run while a frame drains.
//
// Ports
//   clk             system clock, all logic on the rising edge
//   rst             synchronous active-high reset, overrides everything
//   conv_done       done level from the conv wrapper; a rising edge starts a frame
//   result_in       parallel result array, sampled on the frame edge
//   cycle_count_in  conv cycle count, sampled on the frame edge
//   out_valid       beat valid
//   out_ready       consumer accepts a beat when out_valid && out_ready
//   out_data        result element, or the cycle count on the trailer beat
//   out_row         row index of the current beat (0 on the trailer)
//   out_col         column index of the current beat (0 on the trailer)
//   out_is_count    high only on the trailer beat
//   out_last        high only on the trailer beat (end of frame)
//   busy            a frame is being streamed
//   overrun         sticky: a frame edge arrived while busy and was dropped
//   frame_count     completed frames, wraps 0xFFFF -> 0
module conv_result_streamer #(
  parameter int ROWS       = 8,
  parameter int COLS       = 10,
  parameter int DATA_WIDTH = 32,
  localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int COL_W     = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     conv_done,
  input  logic [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0] result_in,
  input  logic [DATA_WIDTH-1:0]                    cycle_count_in,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [DATA_WIDTH-1:0]                    out_data,
  output logic [ROW_W-1:0]                         out_row,
  output logic [COL_W-1:0]                         out_col,
  output logic                                     out_is_count,
  output logic                                     out_last,
  output logic                                     busy,
  output logic                                     overrun,
  output logic [15:0]                              frame_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_TRAILER
  } state_t;

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  state_t                                     state, state_n;
  logic                                       done_q;
  logic [ROW_W-1:0]                           row_q;
  logic [COL_W-1:0]                           col_q;
  logic [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0]  snap;
  logic [DATA_WIDTH-1:0]                      snap_count;

  logic frame_edge;
  logic accept;
  logic load;

  assign frame_edge = conv_done && !done_q;
  assign accept     = out_valid && out_ready;
  assign busy       = (state != ST_IDLE);

  // NOTE: every output of a combinational block gets a default at the top;
  // any path that leaves one unassigned would otherwise infer a latch.
  always_comb begin
    state_n      = state;
    load         = 1'b0;
    out_valid    = 1'b0;
    out_data     = '0;
    out_row      = '0;
    out_col      = '0;
    out_is_count = 1'b0;
    out_last     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_edge) begin
          load    = 1'b1;
          state_n = ST_STREAM;
        end
      end
      ST_STREAM: begin
        out_valid = 1'b1;
        out_data  = snap[row_q][col_q];
        out_row   = row_q;
        out_col   = col_q;
        if (accept && row_q == ROW_LAST && col_q == COL_LAST) state_n = ST_TRAILER;
      end
      ST_TRAILER: begin
        out_valid    = 1'b1;
        out_data     = snap_count;
        out_is_count = 1'b1;
        out_last     = 1'b1;
        if (out_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // NOTE: the snapshot buffer is cleared on reset so nothing from an aborted
  // frame can ever be observed; it is flops, not a RAM, so this is legal.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      done_q      <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      snap        <= '0;
      snap_count  <= '0;
      overrun     <= 1'b0;
      frame_count <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // sees the pre-edge values of its neighbours.
      state  <= state_n;
      done_q <= conv_done;

      if (load) begin
        snap       <= result_in;
        snap_count <= cycle_count_in;
        row_q      <= '0;
        col_q      <= '0;
      end else if (state == ST_STREAM && accept) begin
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end

      // An edge while busy (including the trailer-accept cycle) is dropped.
      if (frame_edge && busy) overrun <= 1'b1;

      if (state == ST_TRAILER && out_ready) frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_conv_result_streamer.sv
module tb_conv_result_streamer;

  localparam int ROWS  = 8;
  localparam int COLS  = 10;
  localparam int DW    = 32;
  localparam int BEATS = ROWS * COLS + 1;

  logic                               clk = 1'b0;
  logic                               rst;
  logic                               conv_done;
  logic [ROWS-1:0][COLS-1:0][DW-1:0]  result_in;
  logic [DW-1:0]                      cycle_count_in;
  logic                               out_valid;
  logic                               out_ready;
  logic [DW-1:0]                      out_data;
  logic [2:0]                         out_row;
  logic [3:0]                         out_col;
  logic                               out_is_count;
  logic                               out_last;
  logic                               busy;
  logic                               overrun;
  logic [15:0]                        frame_count;

  int checks = 0;
  int errors = 0;

  conv_result_streamer #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .conv_done      (conv_done),
    .result_in      (result_in),
    .cycle_count_in (cycle_count_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_row        (out_row),
    .out_col        (out_col),
    .out_is_count   (out_is_count),
    .out_last       (out_last),
    .busy           (busy),
    .overrun        (overrun),
    .frame_count    (frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pack(input logic v, input logic ic, input logic l,
                                       input logic [2:0] r, input logic [3:0] c,
                                       input logic [31:0] d);
    return {22'b0, v, ic, l, r, c, d};
  endfunction

  function automatic logic [63:0] dut_beat();
    return pack(out_valid, out_is_count, out_last, out_row, out_col, out_data);
  endfunction

  // Expected beat k of a frame built from result[r][c] = r*100 + c.
  function automatic logic [63:0] exp_beat(input int k, input logic [31:0] count);
    int r;
    int c;
    if (k == BEATS - 1) return pack(1'b1, 1'b1, 1'b1, 3'd0, 4'd0, count);
    r = k / COLS;
    c = k % COLS;
    return pack(1'b1, 1'b0, 1'b0, r[2:0], c[3:0], 32'(r * 100 + c));
  endfunction

  task automatic load_pattern();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        result_in[r][c] = 32'(r * 100 + c);
  endtask

  // Raises conv_done for one cycle; checks that out_valid rises one cycle later.
  task automatic pulse(input string tag);
    check({tag, "_valid_before"}, {63'b0, out_valid}, 64'd0);
    conv_done = 1'b1;
    step();
    conv_done = 1'b0;
    check({tag, "_latency1"}, {63'b0, out_valid}, 64'd1);
  endtask

  // Drains one frame starting on a cycle where beat 0 is presented.
  // action 1: raise a one-cycle conv_done edge when beat hook is presented.
  // action 2: assert rst when beat hook is presented and return.
  task automatic drain(input string tag, input bit rnd, input int hook, input int action,
                       output int beats);
    int k = 0;
    int cyc = 0;
    bit pulsed = 1'b0;
    while (k < BEATS && cyc < 2000) begin
      if (pulsed) begin
        conv_done = 1'b0;
        pulsed = 1'b0;
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      check($sformatf("%s_beat%0d", tag, k), dut_beat(), exp_beat(k, 32'd523));
      if (k == hook && action == 2) begin
        rst = 1'b1;
        step();
        beats = k;
        return;
      end
      if (k == hook && action == 1 && !conv_done && cyc >= 0) begin
        conv_done = 1'b1;
        pulsed = 1'b1;
        hook = -1;
      end
      if (out_ready && out_valid) k++;
      step();
      cyc++;
    end
    if (pulsed) conv_done = 1'b0;
    out_ready = 1'b1;
    beats = k;
  endtask

  initial begin
    int beats;
    int extra;

    rst            = 1'b1;
    conv_done      = 1'b0;
    out_ready      = 1'b0;
    cycle_count_in = 32'd523;
    load_pattern();
    step();
    step();
    rst = 1'b0;

    // Reset state.
    check("rst_beat", dut_beat(), 64'd0);
    check("rst_busy_overrun", {62'b0, busy, overrun}, 64'd0);
    check("rst_frame_count", {48'b0, frame_count}, 64'd0);

    // 1: full frame, out_ready held high.
    out_ready = 1'b1;
    pulse("t1");
    drain("t1", 1'b0, -1, 0, beats);
    check("t1_beats", beats, BEATS);
    check("t1_valid_after", {63'b0, out_valid}, 64'd0);
    check("t1_frame_count", {48'b0, frame_count}, 64'd1);
    check("t1_busy_after", {63'b0, busy}, 64'd0);

    // 2+3: random backpressure; result_in corrupted one cycle after capture.
    step();
    pulse("t2");
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        result_in[r][c] = 32'hFFFF_FFFF;
    cycle_count_in = 32'hFFFF_FFFF;
    drain("t2", 1'b1, -1, 0, beats);
    check("t2_beats", beats, BEATS);
    check("t2_frame_count", {48'b0, frame_count}, 64'd2);
    check("t2_overrun", {63'b0, overrun}, 64'd0);
    load_pattern();
    cycle_count_in = 32'd523;

    // 4: second edge at beat 40 is dropped with overrun; a third edge later streams.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t4_fc_cleared", {48'b0, frame_count}, 64'd0);
    pulse("t4a");
    cycle_count_in = 32'd999;
    drain("t4a", 1'b0, 40, 1, beats);
    check("t4a_beats", beats, BEATS);
    check("t4a_overrun", {63'b0, overrun}, 64'd1);
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) extra++;
      step();
    end
    check("t4_no_second_frame", extra, 0);
    check("t4a_frame_count", {48'b0, frame_count}, 64'd1);
    cycle_count_in = 32'd523;
    pulse("t4b");
    drain("t4b", 1'b0, -1, 0, beats);
    check("t4b_beats", beats, BEATS);
    check("t4b_frame_count", {48'b0, frame_count}, 64'd2);
    check("t4b_overrun_sticky", {63'b0, overrun}, 64'd1);

    // 5: reset at beat 30 aborts; conv_done held through release starts a frame.
    step();
    pulse("t5");
    drain("t5", 1'b0, 30, 2, beats);
    check("t5_abort_beat", beats, 30);
    check("t5_after_rst", {61'b0, out_valid, busy, overrun}, 64'd0);
    check("t5_after_rst_fc", {48'b0, frame_count}, 64'd0);
    conv_done = 1'b1;
    step();
    rst = 1'b0;
    check("t5_valid_at_release", {63'b0, out_valid}, 64'd0);
    step();
    check("t5_latency1", {63'b0, out_valid}, 64'd1);

    // 6: conv_done stays high for 200 cycles in total -> exactly one frame.
    drain("t6", 1'b0, -1, 0, beats);
    check("t6_beats", beats, BEATS);
    extra = 0;
    for (int i = 0; i < 200 - 2 - BEATS; i++) begin
      if (out_valid) extra++;
      step();
    end
    check("t6_no_retrigger", extra, 0);
    check("t6_frame_count", {48'b0, frame_count}, 64'd1);
    check("t6_overrun", {63'b0, overrun}, 64'd0);
    conv_done = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
